// File: rtl/pc_ifid_pipe_pkg.sv
// pc_ifid_pipe_pkg: shared encodings for the fetch stage and IF/ID latch.
package pc_ifid_pipe_pkg;
  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_J   = 2'b10,
    PCSRC_JR  = 2'b11
  } pcsrc_e;
  localparam logic [31:0] NOP = 32'h0;
  typedef enum logic [1:0] {WD_RUN, WD_STALL, WD_TIMEOUT} wd_state_e;
  function automatic logic [31:0] align4(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/pc_ifid_pipe_if.sv
// pc_ifid_pipe_if: control, target and status signals of the fetch stage.
interface pc_ifid_pipe_if #(parameter int CNT_W = 16);
  logic              PCWrite;
  logic              IF_ID_Write;
  logic              IF_ID_flush;
  logic [1:0]        PCSrc;
  logic [31:0]       BranchTarget;
  logic [31:0]       JumpTarget;
  logic [31:0]       JumpRegTarget;
  logic [31:0]       Instr_in;
  logic [31:0]       PC;
  logic [31:0]       IF_ID_Instr;
  logic [31:0]       IF_ID_PCPlus4;
  logic              IF_ID_Valid;
  logic [CNT_W-1:0]  StallCount;
  logic [CNT_W-1:0]  FlushCount;
  logic              StallTimeout;
  modport master (
    output PCWrite, IF_ID_Write, IF_ID_flush, PCSrc, BranchTarget, JumpTarget, JumpRegTarget, Instr_in,
    input  PC, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, StallCount, FlushCount, StallTimeout
  );
  modport slave (
    input  PCWrite, IF_ID_Write, IF_ID_flush, PCSrc, BranchTarget, JumpTarget, JumpRegTarget, Instr_in,
    output PC, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, StallCount, FlushCount, StallTimeout
  );
endinterface

// File: rtl/pc_ifid_pipe_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
module sat_counter #(parameter int W = 16) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q, q_d;
  always_comb q_d = clr_i ? '0 : (inc_i && !(&q_q)) ? q_q + W'(1) : q_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) q_q <= '0;
    else q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/pc_ifid_pipe.sv
// pc_ifid_pipe: PC register, IF/ID latch, stall/flush counters and stall watchdog.
module pc_ifid_pipe
  import pc_ifid_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          STALL_LIMIT = 8,
  parameter int          CNT_W       = 16
) (
  input logic           Clk,
  input logic           Reset,
  pc_ifid_pipe_if.slave bus
);
  localparam int RW = $clog2(STALL_LIMIT + 1);
  logic [31:0] pc_q, pc_d, pc_plus4, instr_q, instr_d, pcp4_q, pcp4_d;
  logic        valid_q, valid_d, stall;
  logic [RW-1:0] run_q, run_d;
  wd_state_e   st_q, st_d;
  assign pc_plus4 = pc_q + 32'd4;
  assign stall    = !bus.PCWrite && !bus.IF_ID_Write && !bus.IF_ID_flush;
  always_comb begin
    pc_d    = !bus.PCWrite ? pc_q :
              bus.PCSrc == PCSRC_BR ? align4(bus.BranchTarget) :
              bus.PCSrc == PCSRC_J  ? align4(bus.JumpTarget) :
              bus.PCSrc == PCSRC_JR ? align4(bus.JumpRegTarget) : pc_plus4;
    instr_d = bus.IF_ID_flush ? NOP : bus.IF_ID_Write ? bus.Instr_in : instr_q;
    pcp4_d  = bus.IF_ID_flush ? 32'h0 : bus.IF_ID_Write ? pc_plus4 : pcp4_q;
    valid_d = bus.IF_ID_flush ? 1'b0 : bus.IF_ID_Write ? 1'b1 : valid_q;
  end
  // run_d is the stall run length including this cycle; the limit check uses it directly
  always_comb begin
    st_d  = st_q;
    run_d = run_q;
    if (stall && st_q != WD_TIMEOUT) begin
      run_d = (st_q == WD_RUN) ? RW'(1) : run_q + RW'(1);
      st_d  = (run_d == RW'(STALL_LIMIT)) ? WD_TIMEOUT : WD_STALL;
    end else if (st_q == WD_STALL) begin
      run_d = '0;
      st_d  = WD_RUN;
    end
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      pcp4_q  <= 32'h0;
      valid_q <= 1'b0;
      run_q   <= '0;
      st_q    <= WD_RUN;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      run_q   <= run_d;
      st_q    <= st_d;
    end
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(Clk), .rst(Reset), .clr_i(1'b0), .inc_i(stall), .q_o(bus.StallCount)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(Clk), .rst(Reset), .clr_i(1'b0), .inc_i(bus.IF_ID_flush), .q_o(bus.FlushCount)
  );
  assign bus.PC            = pc_q;
  assign bus.IF_ID_Instr   = instr_q;
  assign bus.IF_ID_PCPlus4 = pcp4_q;
  assign bus.IF_ID_Valid   = valid_q;
  assign bus.StallTimeout  = (st_q == WD_TIMEOUT);
endmodule

// File: doc/pc_ifid_pipe.md
PC_IFID_PIPE -- requirements
Module: pc_ifid_pipe

Interface
REQ-001 Parameters SHALL be:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- STALL_LIMIT, 8, consecutive stall cycles that trigger the watchdog.
- CNT_W, 16, width of the performance counters.
REQ-002 Ports SHALL be:
- Clk  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- PCWrite  in  1  PC update enable from hazard detection.
- IF_ID_Write  in  1  IF/ID latch enable.
- IF_ID_flush  in  1  IF/ID squash request.
- PCSrc  in  2  next-PC select: 00 sequential, 01 branch, 10 jump, 11 jump-register.
- BranchTarget  in  32  branch target address.
- JumpTarget  in  32  jump target address.
- JumpRegTarget  in  32  register-sourced jump target address.
- Instr_in  in  32  instruction memory read data for the current PC.
- PC  out  32  current fetch address.
- IF_ID_Instr  out  32  latched instruction.
- IF_ID_PCPlus4  out  32  latched PC+4.
- IF_ID_Valid  out  1  IF/ID contents are a real instruction.
- StallCount  out  CNT_W  total stall cycles.
- FlushCount  out  CNT_W  total flush cycles.
- StallTimeout  out  1  sticky watchdog flag.

Function
REQ-003 nextPC SHALL be selected by PCSrc: PC+4, BranchTarget, JumpTarget or JumpRegTarget.
REQ-004 PC+4 SHALL wrap modulo 2^32, so 32'hFFFF_FFFC becomes 32'h0000_0000.
REQ-005 Target bits [1:0] SHALL be forced to 00 before loading, so PC[1:0] is always 00.
REQ-006 On each rising Clk, PC SHALL load nextPC when PCWrite=1 and hold when PCWrite=0.
REQ-007 IF/ID SHALL update on the same edge with this priority:
- IF_ID_flush=1: Instr <- 32'h0 (NOP), PCPlus4 <- 0, Valid <- 0. Flush overrides IF_ID_Write.
- else IF_ID_Write=1: Instr <- Instr_in, PCPlus4 <- PC+4 of the pre-edge PC, Valid <- 1.
- else: hold all fields.
REQ-008 A stall cycle SHALL be PCWrite=0, IF_ID_Write=0, IF_ID_flush=0.
REQ-009 A flush cycle SHALL be IF_ID_flush=1, regardless of the other enables.
REQ-010 PCWrite=1 with IF_ID_Write=0 and flush=0 SHALL advance PC, hold IF/ID, and count as neither stall nor flush.
REQ-011 StallCount SHALL increment by 1 per stall cycle and FlushCount by 1 per flush cycle.
REQ-012 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-013 The watchdog FSM SHALL have states RUN, STALL and TIMEOUT, with a consecutive-stall counter run_cnt:
- RUN: on a stall cycle go to STALL with run_cnt=1; otherwise stay.
- STALL: on a stall cycle, run_cnt+1; on any non-stall cycle, return to RUN with run_cnt=0.
- STALL: when run_cnt reaches STALL_LIMIT, go to TIMEOUT.
- TIMEOUT: absorbing until Reset.
REQ-014 StallTimeout SHALL be 1 exactly when the FSM is in TIMEOUT. It is registered, with no combinational path from the inputs.
REQ-015 Pipeline behaviour (PC, IF/ID, counters) SHALL continue unchanged while in TIMEOUT.
REQ-016 Latency SHALL be 1 cycle from the enables to the PC and IF/ID outputs; there is no combinational input-to-output path except none.

Reset
REQ-017 While Reset=1, independent of Clk, the outputs SHALL immediately be:
- PC = RESET_PC
- IF_ID_Instr = 0, IF_ID_PCPlus4 = 0, IF_ID_Valid = 0
- StallCount = 0, FlushCount = 0
- FSM = RUN, run_cnt = 0, StallTimeout = 0
REQ-018 Reset asserted mid-stall or mid-flush SHALL discard all in-progress state; the first edge after deassertion behaves as a normal cycle.

Structure
REQ-019 A shared package SHALL hold:
- PCSrc encodings (PCSRC_SEQ, PCSRC_BR, PCSRC_J, PCSRC_JR).
- The NOP encoding 32'h0.
- The watchdog state enum.
REQ-020 One sub-module, sat_counter (parameter width, inc input, sync clear), SHALL be instantiated twice, for StallCount and FlushCount.

Verification
REQ-021 Reset then 3 cycles of PCWrite=IF_ID_Write=1, PCSrc=00, Instr_in=32'h2008_0005 -> PC=0,4,8,C; IF_ID_PCPlus4=C; Valid=1.
REQ-022 PC=32'h40, 2 stall cycles -> PC stays 40; IF/ID holds; StallCount=2; StallTimeout=0.
REQ-023 PC=32'h40, PCSrc=01, BranchTarget=32'h103, IF_ID_flush=1, IF_ID_Write=0, PCWrite=1 -> PC=32'h100; IF_ID_Instr=0; Valid=0; FlushCount=1.
REQ-024 8 consecutive stall cycles with STALL_LIMIT=8 -> StallTimeout=1 after the 8th edge and stays 1 after the stall ends.
REQ-025 Sequential fetch from PC=32'hFFFF_FFFC -> PC=0.
REQ-026 CNT_W=4 with 20 stalls -> StallCount=15.
REQ-027 Reset pulsed between edges mid-stall -> all outputs return to their reset values immediately.
